logic_op_sequencer: RTL and testbench

//  Initiator side of the logic-unit operand interface: accepts logic-op commands over a

---
 rtl/logic_op_sequencer_pkg.sv | 23 ++
 rtl/logic_op_sequencer_regfile.sv | 37 +++
 rtl/logic_op_sequencer.sv | 141 ++++++++++++++
 tb/tb_logic_op_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_sequencer_pkg.sv
// Shared definitions for the logic-op sequencer: operand width, logic function codes, FSM states.
// Optional build macro LOGIC_ZFLAG_EN (see logic_op_sequencer.sv) adds the rsp_zero flag.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package logic_op_sequencer_pkg;

    localparam int REG_W = `REG_WIDTH;

    localparam logic [1:0] LOG_AND = 2'b00;
    localparam logic [1:0] LOG_OR  = 2'b01;
    localparam logic [1:0] LOG_NOR = 2'b10;
    localparam logic [1:0] LOG_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } seq_state_t;

endpackage

// File: rtl/logic_op_sequencer_regfile.sv
// Private operand register file: two asynchronous read ports, one synchronous write port,
// cleared by the asynchronous reset.
module logic_regfile
    import logic_op_sequencer_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/logic_op_sequencer.sv
// Command sequencer for the combinational logic unit: READ operands, EXEC, write back, respond.
// Build macro LOGIC_ZFLAG_EN adds the registered rsp_zero result flag.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module logic_op_sequencer
    import logic_op_sequencer_pkg::*;
#(
    parameter int DATA_W = `REG_WIDTH,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_func,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] first_op,
    output logic [DATA_W-1:0] second_op,
    output logic [1:0]        log_func,
    input  logic [DATA_W-1:0] logic_i_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
`ifdef LOGIC_ZFLAG_EN
    ,
    output logic              rsp_zero
`endif
);

    seq_state_t        state;
    logic [1:0]        func_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic              wb_first;

    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // External loads only land while idle; the writeback owns the port for one WB cycle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_wdata = wr_data;
        if (state == ST_IDLE && wr_en) begin
            rf_we = 1'b1;
        end else if (state == ST_WB && wb_first) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = rsp_data;
        end
    end

    logic_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1_q),
        .rd_data_a (rf_data_a),
        .rd_addr_b (rs2_q),
        .rd_data_b (rf_data_b),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            first_op  <= '0;
            second_op <= '0;
            log_func  <= LOG_AND;
            func_q    <= LOG_AND;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_first  <= 1'b0;
        end else begin
            wb_first <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        func_q    <= cmd_func;
                        rs1_q     <= cmd_rs1;
                        rs2_q     <= cmd_rs2;
                        rd_q      <= cmd_rd;
                        cmd_ready <= 1'b0;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    first_op  <= rf_data_a;
                    second_op <= rf_data_b;
                    log_func  <= func_q;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    rsp_data  <= logic_i_data;
                    rsp_valid <= 1'b1;
                    wb_first  <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LOGIC_ZFLAG_EN
    // Zero flag is captured on the same edge as rsp_data so the two always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_zero <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_zero <= (logic_i_data == '0);
        end
    end
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer with a behavioural logic unit; honours LOGIC_ZFLAG_EN.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module tb_logic_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_func;
    logic [2:0]  cmd_rs1, cmd_rs2, cmd_rd;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] first_op, second_op;
    logic [1:0]  log_func;
    logic [31:0] logic_i_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
`ifdef LOGIC_ZFLAG_EN
    logic        rsp_zero;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] res;
    int          lat;

    always #5 clk = ~clk;

    // Stand-in for the combinational logic unit that the parent would normally attach.
    always_comb begin
        case (log_func)
            2'b00:   logic_i_data = first_op & second_op;
            2'b01:   logic_i_data = first_op | second_op;
            2'b10:   logic_i_data = ~(first_op | second_op);
            default: logic_i_data = first_op ^ second_op;
        endcase
    end

    logic_op_sequencer #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_func     (cmd_func),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_rd       (cmd_rd),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .first_op     (first_op),
        .second_op    (second_op),
        .log_func     (log_func),
        .logic_i_data (logic_i_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data)
`ifdef LOGIC_ZFLAG_EN
        ,
        .rsp_zero     (rsp_zero)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic loadReg(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Drives a command until accepted; returns at the negedge of the READ cycle.
    task automatic issueCmd(input logic [1:0] func, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic [2:0] rd);
        int waited;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_func  = func;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_rd    = rd;
        waited    = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts cycles from the accept cycle (cycle 0) to the first cycle with rsp_valid.
    task automatic waitRsp(output logic [31:0] data, output int cycles);
        cycles = 1;
        while (!rsp_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (!rsp_valid) checkOutput("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        checkOutput("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        data = rsp_data;
    endtask

    task automatic applyStimulus(input logic [1:0] func, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic [2:0] rd,
                                 output logic [31:0] data, output int cycles);
        issueCmd(func, rs1, rs2, rd);
        waitRsp(data, cycles);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_func  = 2'b00;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        cmd_rd    = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'h0);
        checkOutput("rst_first_op", first_op, 32'h0);
        checkOutput("rst_second_op", second_op, 32'h0);
        checkOutput("rst_log_func", {30'd0, log_func}, 32'd0);
`ifdef LOGIC_ZFLAG_EN
        checkOutput("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
`endif
        rst = 1'b0;

        // Reset while the OR command sits in EXEC.
        loadReg(3'd1, 32'hF0F0_F0F0);
        loadReg(3'd2, 32'h0FF0_0FF0);
        issueCmd(2'b01, 3'd1, 3'd2, 3'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("midrst_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
        applyStimulus(2'b01, 3'd3, 3'd3, 3'd0, res, lat);
        checkOutput("midrst_r3_clear", res, 32'h0);

        // OR with latency, then read r3 back through an AND to confirm writeback.
        loadReg(3'd1, 32'hF0F0_F0F0);
        loadReg(3'd2, 32'h0FF0_0FF0);
        applyStimulus(2'b01, 3'd1, 3'd2, 3'd3, res, lat);
        checkOutput("or_data", res, 32'hFFF0_FFF0);
        checkOutput("or_latency", lat, 32'd3);
        applyStimulus(2'b00, 3'd3, 3'd3, 3'd5, res, lat);
        checkOutput("r3_writeback", res, 32'hFFF0_FFF0);
        repeat (3) @(negedge clk);
        checkOutput("idle_first_op", first_op, 32'hFFF0_FFF0);
        checkOutput("idle_log_func", {30'd0, log_func}, 32'd0);

        // NOR then XOR back to back.
        applyStimulus(2'b10, 3'd1, 3'd2, 3'd6, res, lat);
        checkOutput("nor_data", res, 32'h000F_000F);
        applyStimulus(2'b11, 3'd1, 3'd2, 3'd7, res, lat);
        checkOutput("xor_data", res, 32'hFF00_FF00);
        checkOutput("xor_latency", lat, 32'd3);

        // Consumer stalls for 5 cycles while another command is offered.
        loadReg(3'd1, 32'hA5A5_A5A5);
        rsp_ready = 1'b0;
        applyStimulus(2'b00, 3'd1, 3'd1, 3'd1, res, lat);
        checkOutput("and_data", res, 32'hA5A5_A5A5);
        cmd_valid = 1'b1;
        cmd_func  = 2'b01;
        cmd_rs1   = 3'd2;
        cmd_rs2   = 3'd2;
        cmd_rd    = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold_rsp_data", rsp_data, 32'hA5A5_A5A5);
            checkOutput("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("hold_release_ready", {31'd0, cmd_ready}, 32'd1);
        applyStimulus(2'b01, 3'd1, 3'd1, 3'd0, res, lat);
        checkOutput("r1_after_and", res, 32'hA5A5_A5A5);

        // Load and accept in the same cycle; a load attempted during EXEC must be dropped.
        @(negedge clk);
        checkOutput("pre_wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        wr_en     = 1'b1;
        wr_addr   = 3'd2;
        wr_data   = 32'h1234_5678;
        cmd_valid = 1'b1;
        cmd_func  = 2'b11;
        cmd_rs1   = 3'd2;
        cmd_rs2   = 3'd2;
        cmd_rd    = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_en     = 1'b0;
        @(negedge clk);
        checkOutput("same_cycle_first_op", first_op, 32'h1234_5678);
        wr_en   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_en = 1'b0;
        checkOutput("xor_self_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("xor_self_data", rsp_data, 32'h0);
`ifdef LOGIC_ZFLAG_EN
        checkOutput("xor_self_zero", {31'd0, rsp_zero}, 32'd1);
`endif
        applyStimulus(2'b01, 3'd2, 3'd2, 3'd6, res, lat);
        checkOutput("exec_wr_ignored", res, 32'h1234_5678);
`ifdef LOGIC_ZFLAG_EN
        checkOutput("nonzero_flag", {31'd0, rsp_zero}, 32'd0);
`endif
        applyStimulus(2'b00, 3'd4, 3'd4, 3'd0, res, lat);
        checkOutput("r4_writeback_zero", res, 32'h0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
